// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator over a req/ack handshake with timeout
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   mem_read, mem_write            MEM-stage load / store request (write wins when both set)
//   adr, write_data                byte address and store data from the pipeline
//   read_data                      load data, nonzero only in DONE of a successful load
//   stall                          holds IF/ID/EX/MEM while an access is outstanding
//   err, err_cnt                   one-cycle error pulse in DONE, saturating error count
//   m_req, m_we, m_addr, m_wdata   registered request to data memory (word index)
//   m_ack, m_rdata                 one-cycle completion pulse and read data from memory
module mem_access_unit #(
    parameter logic [31:0] BASE_ADR = 32'h0000_2000,
    parameter int          DEPTH    = 512,
    parameter int          ADDR_W   = 9,
    parameter int          TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       adr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic [31:0]      off;
    logic             err_flag;
    logic             req;
    logic             bad;
    assign req = mem_read | mem_write;
    // range check uses the full 32-bit offset so wrapped addresses below base are caught
    assign off = adr - BASE_ADR;
    assign bad = (adr[1:0] != 2'b00) || (adr < BASE_ADR) || ((off >> 2) >= 32'(DEPTH));
    assign stall = (state == WAIT) || (state == IDLE && req);
    assign err = (state == DONE) && err_flag;
    assign read_data = (state == DONE && !m_we && !err_flag) ? rdata_q : 32'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata_q  <= '0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    m_we     <= mem_write;
                    err_flag <= bad;
                    cnt      <= '0;
                    if (bad) begin
                        state <= DONE;
                    end else begin
                        m_addr  <= off[ADDR_W+1:2];
                        m_wdata <= write_data;
                        m_req   <= 1'b1;
                        state   <= WAIT;
                    end
                end
                // ack is checked before the timeout so an ack on the last cycle succeeds
                WAIT: if (m_ack) begin
                    if (!m_we) rdata_q <= m_rdata;
                    m_req <= 1'b0;
                    state <= DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    m_req    <= 1'b0;
                    err_flag <= 1'b1;
                    state    <= DONE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    if (err_flag && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, corner sequences and randomized accesses against a transaction model
module tb_mem_access_unit;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 512;
    localparam int          AW    = 9;
    localparam int          TMO   = 16;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          lat;
        int          exp_st;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read = 1'b0, mem_write = 1'b0, m_ack = 1'b0;
    logic [31:0]   adr = '0, write_data = '0, m_rdata = '0;
    logic [31:0]   read_data, m_wdata;
    logic          stall, err, m_req, m_we;
    logic [7:0]    err_cnt;
    logic [AW-1:0] m_addr;

    int          n_cmp = 0, n_fail = 0;
    int          lat_cfg = 0, wcnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [int];
    int          ref_cnt = 0;
    vec_t        tbl [14];

    mem_access_unit #(.BASE_ADR(BASE), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .adr(adr),
        .write_data(write_data), .read_data(read_data), .stall(stall), .err(err),
        .err_cnt(err_cnt), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // memory device: acks after lat_cfg cycles of m_req (0 = never), commits on ack
    always @(negedge clk) begin
        wcnt  <= m_req ? wcnt + 1 : 0;
        m_ack <= force_ack || (m_req && lat_cfg != 0 && wcnt + 1 == lat_cfg);
        if (m_req && lat_cfg != 0 && wcnt + 1 == lat_cfg) begin
            m_rdata <= mem[m_addr];
            if (m_we) mem[m_addr] <= m_wdata;
        end else begin
            m_rdata <= $urandom;
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic is_bad(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= 32'(DEPTH));
    endfunction

    // transaction-level reference: outcome of one request from the address/latency rules
    function automatic void model(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] wd, input int lat, output int st,
                                  output logic e, output logic [31:0] rdv);
        logic [31:0] off;
        logic        ok;
        int          idx;
        off = a - BASE;
        idx = int'(off >> 2);
        ok  = lat >= 1 && lat <= TMO;
        e   = is_bad(a) || !ok;
        st  = is_bad(a) ? 1 : (ok ? lat + 1 : TMO + 1);
        rdv = (rd && !wr && !e) ? (ref_mem.exists(idx) ? ref_mem[idx] : (32'hDEAD0000 | idx)) : 32'd0;
        if (wr && !e) ref_mem[idx] = wd;
        if (e && ref_cnt < 255) ref_cnt++;
    endfunction

    // drive one request starting at posedge+1 in IDLE; returns at posedge+1 after DONE with inputs cleared
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int lat, output int st_n, output logic e, output logic [31:0] rdv);
        logic [31:0] off;
        int          exp_req, req_n, cyc;
        bit          done;
        off     = a - BASE;
        exp_req = is_bad(a) ? 0 : ((lat >= 1 && lat <= TMO) ? lat : TMO);
        lat_cfg = lat;
        mem_read = rd; mem_write = wr; adr = a; write_data = wd;
        st_n = 0; req_n = 0; cyc = 0; done = 0; e = 1'b0; rdv = '0;
        while (!done && cyc < 64) begin
            #1;
            if (stall) begin
                st_n++;
                if (cyc == 0) chk("req_low_in_idle", m_req, 0);
                if (m_req) begin
                    req_n++;
                    chk("m_we", m_we, wr);
                    chk("m_addr", m_addr, off[AW+1:2]);
                    if (wr) chk("m_wdata", m_wdata, wd);
                end
                chk("rdata_zero_stalled", read_data, 0);
                chk("err_zero_stalled", err, 0);
                @(posedge clk);
                #1;
            end else begin
                done = 1;
                e    = err;
                rdv  = read_data;
                chk("req_low_in_done", m_req, 0);
            end
            cyc++;
        end
        chk("done_reached", done, 1);
        chk("req_cycles", req_n, exp_req);
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic run(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input int x_st, input logic x_e, input logic [31:0] x_rd,
                       input int x_cnt);
        int          st;
        logic        e;
        logic [31:0] rdv;
        access(rd, wr, a, wd, lat, st, e, rdv);
        chk("stall_cycles", st, x_st);
        chk("err_in_done", e, x_e);
        chk("read_data_done", rdv, x_rd);
        #1;
        chk("err_cnt", err_cnt, x_cnt);
        chk("rdata_zero_idle", read_data, 0);
        chk("err_zero_idle", err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          st;
        logic        e;
        logic [31:0] rdv, a;
        logic        rd, wr;
        int          lat;
        tbl[0]  = '{1'b0, 1'b1, 32'h2004, 32'hA5A5_0001, 3,  4,  1'b0, 32'h0,         0};
        tbl[1]  = '{1'b1, 1'b0, 32'h2004, 32'h0,         3,  4,  1'b0, 32'hA5A5_0001, 0};
        tbl[2]  = '{1'b1, 1'b0, 32'h2004, 32'h0,         1,  2,  1'b0, 32'hA5A5_0001, 0};
        tbl[3]  = '{1'b1, 1'b0, 32'h2004, 32'h0,         1,  2,  1'b0, 32'hA5A5_0001, 0};
        tbl[4]  = '{1'b1, 1'b0, 32'h2002, 32'h0,         1,  1,  1'b1, 32'h0,         1};
        tbl[5]  = '{1'b1, 1'b0, 32'h1FFC, 32'h0,         1,  1,  1'b1, 32'h0,         2};
        tbl[6]  = '{1'b1, 1'b0, 32'h2800, 32'h0,         1,  1,  1'b1, 32'h0,         3};
        tbl[7]  = '{1'b1, 1'b0, 32'h2008, 32'h0,         0,  17, 1'b1, 32'h0,         4};
        tbl[8]  = '{1'b1, 1'b0, 32'h2004, 32'h0,         16, 17, 1'b0, 32'hA5A5_0001, 4};
        tbl[9]  = '{1'b1, 1'b1, 32'h2008, 32'h1234_5678, 2,  3,  1'b0, 32'h0,         4};
        tbl[10] = '{1'b1, 1'b0, 32'h2008, 32'h0,         1,  2,  1'b0, 32'h1234_5678, 4};
        tbl[11] = '{1'b0, 1'b1, 32'h27FC, 32'hCAFE_F00D, 2,  3,  1'b0, 32'h0,         4};
        tbl[12] = '{1'b1, 1'b0, 32'h27FC, 32'h0,         1,  2,  1'b0, 32'hCAFE_F00D, 4};
        tbl[13] = '{1'b1, 1'b0, 32'h2008, 32'h0,         17, 17, 1'b1, 32'h0,         5};
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD0000 | i;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_stall", stall, 0);
        mem_read = 1'b1;
        #1 chk("rst_stall_req", stall, 1);
        mem_read = 1'b0;
        #1 chk("rst_stall_noreq", stall, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            model(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wdata, tbl[i].lat, st, e, rdv);
            run(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wdata, tbl[i].lat,
                tbl[i].exp_st, tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_cnt);
        end

        // stray ack while idle must be ignored
        force_ack = 1'b1;
        @(posedge clk);
        #1 force_ack = 1'b0;
        chk("stray_m_req", m_req, 0);
        chk("stray_stall", stall, 0);
        chk("stray_err", err, 0);
        chk("stray_read_data", read_data, 0);
        @(posedge clk);
        #1;
        chk("stray_m_req2", m_req, 0);
        chk("stray_err2", err, 0);
        chk("stray_err_cnt", err_cnt, ref_cnt);

        // asynchronous reset in the middle of WAIT
        lat_cfg = 0;
        mem_write = 1'b1; adr = 32'h2010; write_data = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        #1 chk("prerst_m_req", m_req, 1);
        #2 rst = 1'b1;
        #1 chk("midrst_m_req", m_req, 0);
        chk("midrst_stall_req", stall, 1);
        mem_write = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_m_we", m_we, 0);
        chk("midrst_m_addr", m_addr, 0);
        chk("midrst_m_wdata", m_wdata, 0);
        chk("midrst_read_data", read_data, 0);
        chk("midrst_err", err, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        ref_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        model(1'b1, 1'b0, 32'h2004, 32'h0, 2, st, e, rdv);
        run(1'b1, 1'b0, 32'h2004, 32'h0, 2, st, e, rdv, ref_cnt);
        chk("postrst_rdata_const", rdv, 32'hA5A5_0001);

        // randomized accesses against the transaction model
        for (int i = 0; i < 60; i++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = rd ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            lat = $urandom_range(0, 18);
            case ($urandom_range(0, 7))
                0: a = BASE + 32'($urandom_range(0, 511) << 2) + 32'($urandom_range(1, 3));
                1: a = BASE - 32'(4 * $urandom_range(1, 1000));
                2: a = BASE + 32'h800 + 32'(4 * $urandom_range(0, 1000));
                3: a = BASE + 32'h7FC;
                default: a = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            model(rd, wr, a, $urandom, lat, st, e, rdv);
            run(rd, wr, a, ref_mem.exists(int'((a - BASE) >> 2)) && wr && !e ? ref_mem[int'((a - BASE) >> 2)] : 32'h0,
                lat, st, e, rdv, ref_cnt);
        end

        // drive the error counter into saturation
        for (int i = 0; i < 260; i++) begin
            model(1'b1, 1'b0, 32'h2001, 32'h0, 1, st, e, rdv);
            access(1'b1, 1'b0, 32'h2001, 32'h0, 1, st, e, rdv);
        end
        #1 chk("err_cnt_saturated", err_cnt, 255);
        chk("err_cnt_model", err_cnt, ref_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
